pe_action_table_ctrl: RTL and testbench
=======================================

// Module: pe_action_table_ctrl
// PURPOSE
//  Sequencer/arbiter owning the single port of pe_action_table. After reset it sweeps the table
//  to zero, then shares the port between one config-write requester (NoC config packets) and
//  NUM_REQ lookup requesters (PE ingress lanes). One access per cycle. Lookups return a
//  registered entry one cycle later. Writes to reserved PIDs 0/1 are rejected and flagged.
// PARAMETERS
//  NUM_REQ       4   number of lookup requesters
//  WR_BURST_MAX  4   max consecutive cfg grants while any lookup is pending (starvation guard)
// PORTS
//  clk           in   1              clock; single clock domain
//  rst           in   1              synchronous reset, active-high
//  cfg_valid     in   1              config write request
//  cfg_ready     out  1              config write accepted this cycle (comb)
//  cfg_pid       in   pid_t          target PID
//  cfg_entry     in   action_table_entry_t  data to write
//  cfg_err       out  1              1-cycle pulse, cycle after an accepted write to PID 0/1
//  lk_valid      in   NUM_REQ        per-lane lookup request
//  lk_ready      out  NUM_REQ        one-hot grant (comb); lookup accepted
//  lk_pid        in   NUM_REQ*pid_t  per-lane lookup PID (packed, lane 0 in LSBs)
//  rsp_valid     out  NUM_REQ        one-hot, 1 cycle after grant, 1-cycle pulse
//  rsp_entry     out  action_table_entry_t  registered lookup data
//  rsp_rsvd      out  1              with rsp_valid: looked-up PID was 0/1 (entry forced '0)
//  init_done     out  1              high once table sweep complete
//  at_write_en   out  1              to table write_en
//  at_pid        out  pid_t          to table pid
//  at_w_entry    out  action_table_entry_t  to table w_entry
//  at_entry      in   action_table_entry_t  from table entry (comb read)
// BEHAVIOUR
//  - Reset (rst high at posedge): state=INIT, sweep_ptr=2, rr_ptr=0, burst_cnt=0; all registered
//    outputs 0 (rsp_valid, rsp_entry, rsp_rsvd, cfg_err, init_done). While rst high all comb
//    outputs 0 (cfg_ready, lk_ready, at_write_en); in-flight responses are dropped.
//  - INIT: at_write_en=1, at_pid=sweep_ptr, at_w_entry='0; sweep_ptr++ each cycle; after writing
//    PAT_SIZE-1 go RUN (PAT_SIZE-2 cycles, 14 for PAT_SIZE=16). cfg_ready=lk_ready=0 in INIT.
//  - RUN: init_done=1. Grant order per cycle:
//     cfg wins if cfg_valid && (lk_valid==0 || burst_cnt<WR_BURST_MAX); else lookup round-robin
//     starting at rr_ptr (lowest index >= rr_ptr with lk_valid, wrapping).
//  - cfg grant: cfg_ready=1, at_pid=cfg_pid, at_w_entry=cfg_entry, at_write_en=(cfg_pid>=2).
//    PID 0/1: no write, cfg_err=1 next cycle. burst_cnt++ (saturating) if any lk_valid, else 0.
//  - lookup grant lane g: lk_ready[g]=1, at_pid=lk_pid[g], at_write_en=0; next cycle
//    rsp_valid[g]=1, rsp_entry=at_entry (or '0 and rsp_rsvd=1 if PID<2); rr_ptr=(g+1)%NUM_REQ;
//    burst_cnt=0.
//  - No grant: at_write_en=0, at_pid=0; rsp_valid=0 next cycle.
//  - Write cycle N then lookup same PID cycle N+1 returns new data (no bypass needed, port serial).
//  - Requesters hold valid/pid stable until ready; ready is never asserted without valid.
//  - rst mid-sweep or mid-traffic: restart INIT from PID 2; no partial responses emitted.
// STRUCTURE
//  - pe_types: pid_t, action_table_entry_t, PAT_SIZE (existing); add PAT_RSVD_PIDS=2 and
//    enum pat_ctrl_state_t {PAT_INIT, PAT_RUN}.
//  - Sub-module pe_rr_arbiter (NUM_REQ, req/ptr in, one-hot gnt out, comb) for lane selection;
//    reusable by other PE arbitration points.
//  - Controller instantiates nothing else; pe_action_table instantiated beside it at PE level.
// TESTING
//  1 Reset release: at_write_en=1 with at_pid 2..15 over 14 cycles, entries '0; init_done=1 cycle 15.
//  2 cfg write pid=5 entry=A, next cycle lane2 lookup pid=5 -> rsp_valid=4'b0100, rsp_entry=A.
//  3 cfg write pid=1 -> cfg_ready=1, at_write_en=0, cfg_err pulse next cycle; later lookup pid=1
//    -> rsp_rsvd=1, rsp_entry='0.
//  4 All 4 lanes valid continuously, no cfg -> grants lane0,1,2,3,0 in successive cycles.
//  5 cfg_valid held high + lane1 valid -> 4 cfg grants, then lane1 granted, then cfg resumes.
//  6 rst asserted during sweep (pid=7) and during pending lookup -> no rsp_valid, sweep restarts at 2.

Source files
------------

// File: rtl/pe_types.sv
// Shared PE types: action-table PID/entry formats and the table controller state encoding.
package pe_types;

    localparam int unsigned PAT_SIZE      = 16;
    localparam int unsigned PID_W         = $clog2(PAT_SIZE);
    localparam int unsigned PAT_RSVD_PIDS = 2;

    typedef logic [PID_W-1:0] pid_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] action;
        logic [3:0] port;
        logic [7:0] meta;
    } action_table_entry_t;

    typedef enum logic {PAT_INIT, PAT_RUN} pat_ctrl_state_t;

    function automatic logic is_rsvd_pid(input pid_t pid);
        return pid < pid_t'(PAT_RSVD_PIDS);
    endfunction

endpackage

// File: rtl/pe_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or above ptr,
// wrapping around. One-hot grant, all-zero when nothing requests.
module pe_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            // ptr is always < NUM_REQ, so a single subtraction wraps the index
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_action_table_ctrl.sv
// Owner of the single action-table port: zero-sweeps the table after reset, then arbitrates
// config writes against round-robin lane lookups, returning registered lookup data.
module pe_action_table_ctrl
    import pe_types::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned WR_BURST_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  pid_t                       cfg_pid,
    input  action_table_entry_t        cfg_entry,
    output logic                       cfg_err,
    input  logic [NUM_REQ-1:0]         lk_valid,
    output logic [NUM_REQ-1:0]         lk_ready,
    input  logic [NUM_REQ*PID_W-1:0]   lk_pid,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output action_table_entry_t        rsp_entry,
    output logic                       rsp_rsvd,
    output logic                       init_done,
    output logic                       at_write_en,
    output pid_t                       at_pid,
    output action_table_entry_t        at_w_entry,
    input  action_table_entry_t        at_entry
);

    localparam int unsigned RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BC_W = $clog2(WR_BURST_MAX + 1);

    pat_ctrl_state_t     state_q, state_d;
    pid_t                sweep_q, sweep_d;
    logic [RR_W-1:0]     rr_q, rr_d;
    logic [BC_W-1:0]     burst_q, burst_d;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    action_table_entry_t rsp_entry_q;
    logic                rsp_rsvd_q;
    logic                cfg_err_q;
    logic                init_done_q;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [RR_W-1:0]     gnt_idx;
    pid_t                sel_pid;
    logic                lk_any;
    logic                cfg_win;
    logic                cfg_fire;
    logic                lk_fire;

    pe_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (RR_W)
    ) u_arb (
        .req (lk_valid),
        .ptr (rr_q),
        .gnt (arb_gnt)
    );

    always_comb begin
        gnt_idx = '0;
        sel_pid = '0;
        for (int g = 0; g < NUM_REQ; g++) begin
            if (arb_gnt[g]) begin
                gnt_idx = RR_W'(g);
                sel_pid = lk_pid[g*PID_W +: PID_W];
            end
        end
    end

    assign lk_any  = |lk_valid;
    // Config yields only once it has taken WR_BURST_MAX grants back-to-back against waiting lanes
    assign cfg_win = cfg_valid && (!lk_any || (burst_q < BC_W'(WR_BURST_MAX)));

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        rr_d        = rr_q;
        burst_d     = burst_q;
        cfg_ready   = 1'b0;
        lk_ready    = '0;
        at_write_en = 1'b0;
        at_pid      = '0;
        at_w_entry  = '0;
        cfg_fire    = 1'b0;
        lk_fire     = 1'b0;
        if (!rst) begin
            unique case (state_q)
                PAT_INIT: begin
                    at_write_en = 1'b1;
                    at_pid      = sweep_q;
                    sweep_d     = sweep_q + pid_t'(1);
                    if (sweep_q == pid_t'(PAT_SIZE - 1)) begin
                        state_d = PAT_RUN;
                    end
                end
                PAT_RUN: begin
                    if (cfg_win) begin
                        cfg_ready   = 1'b1;
                        cfg_fire    = 1'b1;
                        at_pid      = cfg_pid;
                        at_w_entry  = cfg_entry;
                        at_write_en = !is_rsvd_pid(cfg_pid);
                        if (!lk_any) begin
                            burst_d = '0;
                        end else if (burst_q != BC_W'(WR_BURST_MAX)) begin
                            burst_d = burst_q + BC_W'(1);
                        end
                    end else if (lk_any) begin
                        lk_ready = arb_gnt;
                        lk_fire  = 1'b1;
                        at_pid   = sel_pid;
                        rr_d     = (gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + RR_W'(1);
                        burst_d  = '0;
                    end
                end
                default: state_d = PAT_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PAT_INIT;
            sweep_q     <= pid_t'(PAT_RSVD_PIDS);
            rr_q        <= '0;
            burst_q     <= '0;
            rsp_valid_q <= '0;
            rsp_entry_q <= '0;
            rsp_rsvd_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            rr_q        <= rr_d;
            burst_q     <= burst_d;
            rsp_valid_q <= lk_fire ? arb_gnt : '0;
            if (lk_fire) begin
                rsp_entry_q <= is_rsvd_pid(sel_pid) ? '0 : at_entry;
            end
            rsp_rsvd_q  <= lk_fire && is_rsvd_pid(sel_pid);
            cfg_err_q   <= cfg_fire && is_rsvd_pid(cfg_pid);
            init_done_q <= (state_d == PAT_RUN);
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_entry = rsp_entry_q;
    assign rsp_rsvd  = rsp_rsvd_q;
    assign cfg_err   = cfg_err_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_pe_action_table_ctrl.sv
// Bench for pe_action_table_ctrl: behavioural table + transaction model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pe_action_table_ctrl;
    import pe_types::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    pid_t                cfg_pid = '0;
    action_table_entry_t cfg_entry = '0;
    logic                cfg_err;
    logic [3:0]          lk_valid = '0;
    logic [3:0]          lk_ready;
    logic [15:0]         lk_pid = '0;
    logic [3:0]          rsp_valid;
    action_table_entry_t rsp_entry;
    logic                rsp_rsvd;
    logic                init_done;
    logic                at_write_en;
    pid_t                at_pid;
    action_table_entry_t at_w_entry;
    action_table_entry_t at_entry;

    int n_chk  = 0;
    int n_fail = 0;

    pe_action_table_ctrl #(.NUM_REQ(4), .WR_BURST_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pid     (cfg_pid),
        .cfg_entry   (cfg_entry),
        .cfg_err     (cfg_err),
        .lk_valid    (lk_valid),
        .lk_ready    (lk_ready),
        .lk_pid      (lk_pid),
        .rsp_valid   (rsp_valid),
        .rsp_entry   (rsp_entry),
        .rsp_rsvd    (rsp_rsvd),
        .init_done   (init_done),
        .at_write_en (at_write_en),
        .at_pid      (at_pid),
        .at_w_entry  (at_w_entry),
        .at_entry    (at_entry)
    );

    always #5 clk = ~clk;

    // Stand-in for pe_action_table: comb read, write on clock edge
    logic [15:0] tab [16];
    initial for (int i = 0; i < 16; i++) tab[i] = '0;
    always @(posedge clk) if (at_write_en) tab[at_pid] <= at_w_entry;
    assign at_entry = action_table_entry_t'(tab[at_pid]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_known = 0;
    bit          m_run;
    int          m_sweep, m_rr, m_burst;
    logic [15:0] m_tab [16];
    logic [3:0]  e_rsp_valid;
    logic [15:0] e_rsp_entry;
    logic        e_rsp_rsvd, e_cfg_err, e_init_done;
    initial for (int i = 0; i < 16; i++) m_tab[i] = '0;

    function automatic int lane_pid(input int l);
        return int'(lk_pid[l*4 +: 4]);
    endfunction

    // kind: 0 none, 1 config write, 2 lookup on lane
    task automatic pick(output int kind, output int lane);
        kind = 0;
        lane = 0;
        if (cfg_valid && (lk_valid == 0 || m_burst < 4)) begin
            kind = 1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (kind == 0 && lk_valid[(m_rr + k) % 4]) begin
                    kind = 2;
                    lane = (m_rr + k) % 4;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        int kind, lane, p;
        if (rst) begin
            m_known = 1; m_run = 0; m_sweep = 2; m_rr = 0; m_burst = 0;
            e_rsp_valid = 0; e_rsp_entry = 0; e_rsp_rsvd = 0; e_cfg_err = 0; e_init_done = 0;
        end else if (m_known) begin
            e_rsp_valid = 0; e_rsp_rsvd = 0; e_cfg_err = 0;
            if (!m_run) begin
                m_tab[m_sweep] = 0;
                if (m_sweep == 15) m_run = 1;
                m_sweep++;
            end else begin
                pick(kind, lane);
                if (kind == 1) begin
                    if (cfg_pid >= 2) m_tab[cfg_pid] = cfg_entry;
                    else e_cfg_err = 1;
                    m_burst = (lk_valid == 0) ? 0 : ((m_burst + 1 > 4) ? 4 : m_burst + 1);
                end else if (kind == 2) begin
                    p = lane_pid(lane);
                    e_rsp_valid = 4'(1 << lane);
                    e_rsp_rsvd  = (p < 2);
                    e_rsp_entry = (p < 2) ? 16'h0 : m_tab[p];
                    m_rr = (lane + 1) % 4;
                    m_burst = 0;
                end
            end
            e_init_done = m_run;
        end
    end

    always @(negedge clk) begin
        int kind, lane;
        logic       x_cfg_ready, x_we;
        logic [3:0] x_lk_ready;
        int         x_pid;
        logic [15:0] x_wdata;
        if (m_known) begin
            x_cfg_ready = 0; x_lk_ready = 0; x_we = 0; x_pid = 0; x_wdata = 0;
            if (!rst) begin
                if (!m_run) begin
                    x_we = 1; x_pid = m_sweep;
                end else begin
                    pick(kind, lane);
                    if (kind == 1) begin
                        x_cfg_ready = 1; x_pid = int'(cfg_pid); x_we = (cfg_pid >= 2);
                        x_wdata = cfg_entry;
                    end else if (kind == 2) begin
                        x_lk_ready = 4'(1 << lane); x_pid = lane_pid(lane);
                    end
                end
                chk("m_at_pid", 32'(at_pid), 32'(x_pid));
                if (x_we) chk("m_at_w_entry", 32'(at_w_entry), 32'(x_wdata));
            end
            chk("m_cfg_ready", 32'(cfg_ready), 32'(x_cfg_ready));
            chk("m_lk_ready", 32'(lk_ready), 32'(x_lk_ready));
            chk("m_at_write_en", 32'(at_write_en), 32'(x_we));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
            chk("m_rsp_rsvd", 32'(rsp_rsvd), 32'(e_rsp_rsvd));
            chk("m_cfg_err", 32'(cfg_err), 32'(e_cfg_err));
            chk("m_init_done", 32'(init_done), 32'(e_init_done));
            if (e_rsp_valid != 0) chk("m_rsp_entry", 32'(rsp_entry), 32'(e_rsp_entry));
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int l, input int p);
        lk_pid[l*4 +: 4] = 4'(p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        tick(); tick();
        @(negedge clk);
        chk("rst_init_done", 32'(init_done), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_we", 32'(at_write_en), 32'h0);
        tick();
        rst = 1'b0;
        // 1: sweep PIDs 2..15, then init_done
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            chk("t1_we", 32'(at_write_en), 32'h1);
            chk("t1_pid", 32'(at_pid), 32'(c + 2));
            chk("t1_wdata", 32'(at_w_entry), 32'h0);
            chk("t1_not_done", 32'(init_done), 32'h0);
        end
        @(negedge clk);
        chk("t1_init_done", 32'(init_done), 32'h1);
        // 2: write then read back PID 5 on lane 2
        tick();
        cfg_valid = 1; cfg_pid = 4'd5; cfg_entry = action_table_entry_t'(16'hA5C3);
        @(negedge clk);
        chk("t2_cfg_ready", 32'(cfg_ready), 32'h1);
        chk("t2_we", 32'(at_write_en), 32'h1);
        tick();
        cfg_valid = 0; lk_valid = 4'b0100; set_lane(2, 5);
        @(negedge clk);
        chk("t2_lk_ready", 32'(lk_ready), 32'h4);
        tick();
        lk_valid = 0;
        @(negedge clk);
        chk("t2_rsp_valid", 32'(rsp_valid), 32'h4);
        chk("t2_rsp_entry", 32'(rsp_entry), 32'hA5C3);
        chk("t2_rsp_rsvd", 32'(rsp_rsvd), 32'h0);
        // 3: reserved PID write rejected, lookup forced to zero
        tick();
        cfg_valid = 1; cfg_pid = 4'd1; cfg_entry = action_table_entry_t'(16'hFFFF);
        @(negedge clk);
        chk("t3_cfg_ready", 32'(cfg_ready), 32'h1);
        chk("t3_we", 32'(at_write_en), 32'h0);
        tick();
        cfg_valid = 0;
        @(negedge clk);
        chk("t3_cfg_err", 32'(cfg_err), 32'h1);
        tick();
        lk_valid = 4'b0001; set_lane(0, 1);
        @(negedge clk);
        chk("t3_cfg_err_pulse", 32'(cfg_err), 32'h0);
        chk("t3_lk_ready", 32'(lk_ready), 32'h1);
        tick();
        lk_valid = 0;
        @(negedge clk);
        chk("t3_rsp_rsvd", 32'(rsp_rsvd), 32'h1);
        chk("t3_rsp_entry", 32'(rsp_entry), 32'h0);
        // bring rr pointer back to lane 0 via a lane-3 lookup
        tick();
        lk_valid = 4'b1000; set_lane(3, 9);
        tick();
        lk_valid = 0;
        tick();
        // 4: all lanes busy -> 0,1,2,3,0
        lk_valid = 4'b1111; set_lane(0, 2); set_lane(1, 3); set_lane(2, 4); set_lane(3, 5);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_grant", 32'(lk_ready), 32'(1 << (c % 4)));
            tick();
        end
        lk_valid = 0;
        tick();
        // 5: cfg burst guard
        cfg_valid = 1; cfg_pid = 4'd6; cfg_entry = action_table_entry_t'(16'h1234);
        lk_valid = 4'b0010; set_lane(1, 6);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t5_cfg_burst", 32'({cfg_ready, lk_ready}), 32'h10);
            tick();
        end
        @(negedge clk);
        chk("t5_lane1", 32'({cfg_ready, lk_ready}), 32'h02);
        tick();
        lk_valid = 0;
        @(negedge clk);
        chk("t5_cfg_resume", 32'(cfg_ready), 32'h1);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("t5_rsp_entry", 32'(rsp_entry), 32'h1234);
        tick();
        cfg_valid = 0;
        // 6: reset mid-sweep and with a lookup in flight
        rst = 1;
        tick();
        rst = 0;
        for (int c = 0; c < 5; c++) @(negedge clk);
        @(negedge clk);
        chk("t6_sweep_pid7", 32'(at_pid), 32'h7);
        #1 rst = 1;
        @(negedge clk);
        chk("t6_rst_we", 32'(at_write_en), 32'h0);
        tick();
        rst = 0;
        @(negedge clk);
        chk("t6_restart_pid", 32'(at_pid), 32'h2);
        chk("t6_restart_we", 32'(at_write_en), 32'h1);
        n = 0;
        while (!init_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_init_done", 32'(init_done), 32'h1);
        tick();
        lk_valid = 4'b0001; set_lane(0, 3);
        @(negedge clk);
        chk("t6_lk_ready", 32'(lk_ready), 32'h1);
        #1 rst = 1;
        tick();
        lk_valid = 0;
        @(negedge clk);
        chk("t6_dropped", 32'(rsp_valid), 32'h0);
        tick();
        rst = 0;
        @(negedge clk);
        chk("t6_no_rsp", 32'(rsp_valid), 32'h0);
        chk("t6_restart2", 32'(at_pid), 32'h2);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
